// File: rtl/pll_mdrp_pkg.sv
// rtl/pll_mdrp_pkg.sv - shared opcodes, command encodings and FSM states for the PLL MDRP master
package pll_mdrp_pkg;

    localparam logic [1:0] OPC_NOP   = 2'b00;
    localparam logic [1:0] OPC_WRITE = 2'b01;
    localparam logic [1:0] OPC_READ  = 2'b10;
    localparam logic [1:0] OPC_ADDR  = 2'b11;

    typedef enum logic [1:0] {
        CMD_WRITE  = 2'd0,
        CMD_READ   = 2'd1,
        CMD_RELOCK = 2'd2,
        CMD_RSVD   = 2'd3
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WDATA,
        ST_RDCMD,
        ST_RDWAIT,
        ST_RST,
        ST_LOCKWAIT,
        ST_DONE
    } state_e;

    // Width of one counter shared by read wait, reset pulse and lock wait.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pll_mdrp_if.sv
// rtl/pll_mdrp_if.sv - command/response bus between a client and the PLL MDRP master
interface pll_mdrp_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchroniser for a single asynchronous level
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops give the first stage a full cycle to resolve.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_mdrp_master.sv
// rtl/pll_mdrp_master.sv - sequences write/read/relock commands onto the PLL MDRP port
module pll_mdrp_master
    import pll_mdrp_pkg::*;
#(
    parameter int READ_LAT     = 2,
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic         mdclk,
    input  logic         reset,
    pll_mdrp_if.slave    cmd,
    output logic [1:0]   mdopc,
    output logic         mdainc,
    output logic [7:0]   mdwdi,
    input  logic [7:0]   mdrdo,
    output logic         pll_reset,
    input  logic         lock
);

    localparam int CNT_W = cnt_width(READ_LAT, RST_CYCLES, LOCK_TIMEOUT);
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'((READ_LAT >= 2) ? READ_LAT - 2 : 0);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LOCK_MAX  = CNT_W'(LOCK_TIMEOUT);

    state_e           state, state_d;
    cmd_op_e          op_q;
    logic [7:0]       addr_q;
    logic [7:0]       wdata_q;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             err_q, err_d;
    logic [7:0]       rdata_q;
    logic             capture;
    logic             rst_drive;
    logic             lock_s;
    logic             accept;

    sync2 u_lock_sync (
        .clk   (mdclk),
        .reset (reset),
        .d     (lock),
        .q     (lock_s)
    );

    assign accept        = cmd.cmd_valid && (state == ST_IDLE);
    assign cmd.cmd_ready = (state == ST_IDLE);
    assign cmd.rsp_valid = (state == ST_DONE);
    assign cmd.rsp_err   = (state == ST_DONE) && err_q;
    assign cmd.rsp_rdata = rdata_q;
    assign mdainc        = 1'b0;
    assign pll_reset     = reset || rst_drive;

    // State, shared counter, error flag, captured command and read data.
    always_ff @(posedge mdclk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            err_q   <= 1'b0;
            op_q    <= CMD_WRITE;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            rdata_q <= 8'h00;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            err_q <= err_d;
            if (accept) begin
                op_q    <= cmd_op_e'(cmd.cmd_op);
                addr_q  <= cmd.cmd_addr;
                wdata_q <= cmd.cmd_wdata;
            end
            if (capture) begin
                rdata_q <= mdrdo;
            end
        end
    end

    // Next state and PLL-side outputs; PLL port is idle except in ADDR/WDATA/RDCMD.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        err_d     = err_q;
        capture   = 1'b0;
        rst_drive = 1'b0;
        mdopc     = OPC_NOP;
        mdwdi     = 8'h00;
        case (state)
            ST_IDLE: begin
                if (cmd.cmd_valid) begin
                    cnt_d = '0;
                    err_d = 1'b0;
                    case (cmd_op_e'(cmd.cmd_op))
                        CMD_WRITE,
                        CMD_READ:   state_d = ST_ADDR;
                        CMD_RELOCK: state_d = ST_RST;
                        default: begin
                            err_d   = 1'b1;
                            state_d = ST_DONE;
                        end
                    endcase
                end
            end
            ST_ADDR: begin
                mdopc   = OPC_ADDR;
                mdwdi   = addr_q;
                state_d = (op_q == CMD_WRITE) ? ST_WDATA : ST_RDCMD;
            end
            ST_WDATA: begin
                mdopc   = OPC_WRITE;
                mdwdi   = wdata_q;
                state_d = ST_DONE;
            end
            ST_RDCMD: begin
                mdopc = OPC_READ;
                if (READ_LAT <= 1) begin
                    capture = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = '0;
                    state_d = ST_RDWAIT;
                end
            end
            ST_RDWAIT: begin
                if (cnt == RD_LAST) begin
                    capture = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            ST_RST: begin
                rst_drive = 1'b1;
                if (cnt == RST_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_LOCKWAIT;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            ST_LOCKWAIT: begin
                if (lock_s) begin
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end else if (cnt == LOCK_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (cnt != LOCK_MAX) begin
                    cnt_d = cnt + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Keep the PLL port quiet while reset is held, whatever state is being left.
        if (reset) begin
            mdopc = OPC_NOP;
            mdwdi = 8'h00;
        end
    end

endmodule

// File: tb/tb_pll_mdrp_master.sv
// tb/tb_pll_mdrp_master.sv - directed self-checking bench for pll_mdrp_master
module tb_pll_mdrp_master;
    import pll_mdrp_pkg::*;

    logic       mdclk = 1'b0;
    logic       reset;
    logic [1:0] mdopc;
    logic       mdainc;
    logic [7:0] mdwdi;
    logic [7:0] mdrdo;
    logic       pll_reset;
    logic       lock;
    logic [7:0] pll_addr;

    int total = 0;
    int bad   = 0;

    pll_mdrp_if bus ();

    pll_mdrp_master #(
        .READ_LAT     (2),
        .RST_CYCLES   (16),
        .LOCK_TIMEOUT (100)
    ) dut (
        .mdclk     (mdclk),
        .reset     (reset),
        .cmd       (bus),
        .mdopc     (mdopc),
        .mdainc    (mdainc),
        .mdwdi     (mdwdi),
        .mdrdo     (mdrdo),
        .pll_reset (pll_reset),
        .lock      (lock)
    );

    always #5 mdclk = ~mdclk;

    // PLL register model: only address 0x05 reads back 0xA5, for one cycle after READ.
    always @(posedge mdclk) begin
        if (mdopc == OPC_ADDR) pll_addr <= mdwdi;
        mdrdo <= (mdopc == OPC_READ && pll_addr == 8'h05) ? 8'hA5 : 8'h00;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d);
        bus.cmd_op    = op;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        bus.cmd_valid = 1'b1;
        check("issue_ready", 32'(bus.cmd_ready), 32'd1);
        @(negedge mdclk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int start, input int budget, output int lat);
        lat = start;
        while (!bus.rsp_valid && lat < budget) begin
            @(negedge mdclk);
            lat++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int n;
        int idx;
        int acc_n;
        int rsp_n;
        bit pend;
        int acc_cyc[4];
        int rsp_cyc[4];
        int rsp_e[4];
        logic [1:0] ops[4];
        int exp_acc[4];
        int exp_rsp[4];
        int exp_err[4];

        ops     = '{2'd0, 2'd3, 2'd1, 2'd3};
        exp_acc = '{0, 4, 6, 11};
        exp_rsp = '{3, 5, 10, 12};
        exp_err = '{0, 1, 0, 1};

        reset         = 1'b1;
        lock          = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_addr  = 8'h00;
        bus.cmd_wdata = 8'h00;
        repeat (3) @(negedge mdclk);

        check("rst_pll_reset", 32'(pll_reset), 32'd1);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_err",   32'(bus.rsp_err), 32'd0);
        check("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        check("rst_mdopc",     32'(mdopc), 32'd0);
        check("rst_mdainc",    32'(mdainc), 32'd0);
        check("rst_mdwdi",     32'(mdwdi), 32'd0);
        reset = 1'b0;
        @(negedge mdclk);
        check("post_rst_pll_reset", 32'(pll_reset), 32'd0);

        // Write 0x23 to 0x12
        issue(2'd0, 8'h12, 8'h23);
        check("wr_addr_opc", 32'(mdopc), 32'h3);
        check("wr_addr_wdi", 32'(mdwdi), 32'h12);
        @(negedge mdclk);
        check("wr_data_opc", 32'(mdopc), 32'h1);
        check("wr_data_wdi", 32'(mdwdi), 32'h23);
        check("wr_no_early_rsp", 32'(bus.rsp_valid), 32'd0);
        wait_rsp(2, 20, lat);
        check("wr_latency", 32'(lat), 32'd3);
        check("wr_err", 32'(bus.rsp_err), 32'd0);
        check("wr_mdainc", 32'(mdainc), 32'd0);
        @(negedge mdclk);

        // Read 0x05
        issue(2'd1, 8'h05, 8'h00);
        check("rd_addr_opc", 32'(mdopc), 32'h3);
        check("rd_addr_wdi", 32'(mdwdi), 32'h05);
        @(negedge mdclk);
        check("rd_cmd_opc", 32'(mdopc), 32'h2);
        check("rd_cmd_wdi", 32'(mdwdi), 32'h00);
        wait_rsp(2, 20, lat);
        check("rd_latency", 32'(lat), 32'd4);
        check("rd_rdata", 32'(bus.rsp_rdata), 32'hA5);
        check("rd_err", 32'(bus.rsp_err), 32'd0);
        @(negedge mdclk);
        check("rd_rdata_hold", 32'(bus.rsp_rdata), 32'hA5);

        // Reserved op on its own
        issue(2'd3, 8'h77, 8'h88);
        wait_rsp(1, 20, lat);
        check("rsvd_latency", 32'(lat), 32'd1);
        check("rsvd_err", 32'(bus.rsp_err), 32'd1);
        check("rsvd_opc", 32'(mdopc), 32'd0);
        check("rsvd_pll_reset", 32'(pll_reset), 32'd0);
        check("rsvd_rdata_hold", 32'(bus.rsp_rdata), 32'hA5);
        @(negedge mdclk);

        // Relock, lock rises 10 cycles after pll_reset falls
        issue(2'd2, 8'h00, 8'h00);
        n = 0;
        while (pll_reset && n < 100) begin
            n++;
            @(negedge mdclk);
        end
        check("relock_rst_width", 32'(n), 32'd16);
        repeat (10) @(negedge mdclk);
        lock = 1'b1;
        wait_rsp(27, 60, lat);
        check("relock_latency", 32'(lat), 32'd30);
        check("relock_err", 32'(bus.rsp_err), 32'd0);
        lock = 1'b0;
        @(negedge mdclk);

        // Relock with lock stuck low: timeout after 100 LOCKWAIT cycles
        issue(2'd2, 8'h00, 8'h00);
        n = 0;
        while (pll_reset && n < 100) begin
            n++;
            @(negedge mdclk);
        end
        check("tmo_rst_width", 32'(n), 32'd16);
        wait_rsp(17, 300, lat);
        check("tmo_latency", 32'(lat), 32'd117);
        check("tmo_err", 32'(bus.rsp_err), 32'd1);
        @(negedge mdclk);

        // Reset during RDWAIT aborts the read
        issue(2'd1, 8'h05, 8'h00);
        @(negedge mdclk);
        @(negedge mdclk);
        reset = 1'b1;
        #1;
        check("abort_pll_reset", 32'(pll_reset), 32'd1);
        @(negedge mdclk);
        check("abort_idle", 32'(bus.cmd_ready), 32'd1);
        check("abort_opc", 32'(mdopc), 32'd0);
        check("abort_no_valid", 32'(bus.rsp_valid), 32'd0);
        check("abort_rdata_clr", 32'(bus.rsp_rdata), 32'd0);
        reset = 1'b0;
        n = 0;
        repeat (6) begin
            @(negedge mdclk);
            if (bus.rsp_valid) n++;
        end
        check("abort_no_rsp", 32'(n), 32'd0);
        issue(2'd0, 8'h34, 8'h56);
        check("post_abort_wr_opc", 32'(mdopc), 32'h3);
        check("post_abort_wr_wdi", 32'(mdwdi), 32'h34);
        wait_rsp(1, 20, lat);
        check("post_abort_wr_lat", 32'(lat), 32'd3);
        check("post_abort_wr_err", 32'(bus.rsp_err), 32'd0);
        @(negedge mdclk);

        // cmd_valid held high: write, reserved, read, reserved back to back
        idx   = 0;
        acc_n = 0;
        rsp_n = 0;
        pend  = 1'b0;
        bus.cmd_op    = ops[0];
        bus.cmd_addr  = 8'h05;
        bus.cmd_wdata = 8'h5A;
        bus.cmd_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) @(negedge mdclk);
            if (pend) begin
                pend = 1'b0;
                idx++;
                if (idx < 4) bus.cmd_op = ops[idx];
                else bus.cmd_valid = 1'b0;
            end
            if (bus.rsp_valid) begin
                if (rsp_n < 4) begin
                    rsp_cyc[rsp_n] = c;
                    rsp_e[rsp_n]   = int'(bus.rsp_err);
                end
                rsp_n++;
            end
            if (bus.rsp_err) check("b2b_rsvd_opc", 32'(mdopc), 32'd0);
            if (bus.cmd_valid && bus.cmd_ready) begin
                if (acc_n < 4) acc_cyc[acc_n] = c;
                acc_n++;
                pend = 1'b1;
            end
        end
        bus.cmd_valid = 1'b0;
        check("b2b_accepts", 32'(acc_n), 32'd4);
        check("b2b_responses", 32'(rsp_n), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < acc_n) check("b2b_acc_cycle", 32'(acc_cyc[i]), 32'(exp_acc[i]));
            if (i < rsp_n) begin
                check("b2b_rsp_cycle", 32'(rsp_cyc[i]), 32'(exp_rsp[i]));
                check("b2b_rsp_err", 32'(rsp_e[i]), 32'(exp_err[i]));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
